// File: rtl/capture_channel_scheduler.sv
// Sweeps NUM_CH signals through one shared capture unit and emits one result beat per enabled channel.
// Optional CAP_SKIP_FIRST_EN: discard the first cap_done edge after each capture-unit clear.
module capture_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int CLR_CYCLES     = 2,
  localparam int IW            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              start,
  output logic              busy,
  output logic              cap_rst,
  output logic              cap_signal,
  input  logic [31:0]       cap_frequency,
  input  logic [31:0]       cap_high_time,
  input  logic [31:0]       cap_low_time,
  input  logic              cap_done,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IW-1:0]     result_ch,
  output logic [31:0]       result_freq,
  output logic [31:0]       result_high,
  output logic [31:0]       result_low,
  output logic              result_timeout,
  output logic              sweep_done
);

  localparam int CW = $clog2(CLR_CYCLES) + 1;

  typedef enum logic [2:0] {
    IDLE, SELECT, CLEAR, MEASURE, OUTPUT, NEXT, DONE
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] mask;
  logic [IW-1:0]     index;
  logic [CW-1:0]     clr_cnt;
  logic [31:0]       tcnt;
  logic              done_q;
  logic              done_qq;
  logic              cap_edge;
  logic              edge_take;
  logic [IW-1:0]     next_idx;
`ifdef CAP_SKIP_FIRST_EN
  logic              first_seen;
`endif

  assign cap_edge = done_q & ~done_qq;
  assign next_idx = index + IW'(1);
`ifdef CAP_SKIP_FIRST_EN
  assign edge_take = cap_edge & first_seen;
`else
  assign edge_take = cap_edge;
`endif

  always_comb begin
    cap_signal = 1'b0;
    if (state != IDLE && state != DONE) cap_signal = sig_in[index];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mask           <= '0;
      index          <= '0;
      clr_cnt        <= '0;
      tcnt           <= '0;
      done_q         <= 1'b0;
      done_qq        <= 1'b0;
      busy           <= 1'b0;
      cap_rst        <= 1'b1;
      result_valid   <= 1'b0;
      result_ch      <= '0;
      result_freq    <= '0;
      result_high    <= '0;
      result_low     <= '0;
      result_timeout <= 1'b0;
      sweep_done     <= 1'b0;
`ifdef CAP_SKIP_FIRST_EN
      first_seen     <= 1'b0;
`endif
    end else begin
      done_q     <= cap_done;
      done_qq    <= done_q;
      sweep_done <= 1'b0;
      cap_rst    <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !busy) begin
            mask  <= ch_enable;
            index <= '0;
            busy  <= 1'b1;
            state <= SELECT;
          end
        end
        SELECT: begin
          if (mask[index]) begin
            clr_cnt <= '0;
            cap_rst <= 1'b1;
            state   <= CLEAR;
          end else begin
            state <= NEXT;
          end
        end
        CLEAR: begin
          if (clr_cnt == CW'(CLR_CYCLES - 1)) begin
            tcnt  <= '0;
            state <= MEASURE;
`ifdef CAP_SKIP_FIRST_EN
            first_seen <= 1'b0;
`endif
          end else begin
            clr_cnt <= clr_cnt + CW'(1);
            cap_rst <= 1'b1;
          end
        end
        MEASURE: begin
          if (edge_take) begin
            result_ch      <= index;
            result_freq    <= cap_frequency;
            result_high    <= cap_high_time;
            result_low     <= cap_low_time;
            result_timeout <= 1'b0;
            result_valid   <= 1'b1;
            state          <= OUTPUT;
          end else if (tcnt == 32'(TIMEOUT_CYCLES - 1)) begin
            result_ch      <= index;
            result_freq    <= '0;
            result_high    <= '0;
            result_low     <= '0;
            result_timeout <= 1'b1;
            result_valid   <= 1'b1;
            state          <= OUTPUT;
          end else begin
            tcnt <= tcnt + 32'd1;
`ifdef CAP_SKIP_FIRST_EN
            if (cap_edge) first_seen <= 1'b1;
`endif
          end
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= NEXT;
          end
        end
        NEXT: begin
          // Disabled channels are stepped over here at one cycle each, so an
          // empty mask completes NUM_CH+2 cycles after start.
          if (index == IW'(NUM_CH - 1)) begin
            sweep_done <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else begin
            index <= next_idx;
            state <= mask[next_idx] ? SELECT : NEXT;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_channel_scheduler.sv
// Directed bench: capture-unit responder, beat-level reference model and per-cycle comparator.
module tb_capture_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int TMO    = 1000;
  localparam int CLR    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sig_in = '0;
  logic [3:0]  ch_enable = '0;
  logic        start = 1'b0;
  logic        busy, cap_rst, cap_signal;
  logic [31:0] cap_frequency = '0, cap_high_time = '0, cap_low_time = '0;
  logic        cap_done = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [1:0]  result_ch;
  logic [31:0] result_freq, result_high, result_low;
  logic        result_timeout, sweep_done;

  capture_channel_scheduler #(
    .NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TMO), .CLR_CYCLES(CLR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .ch_enable(ch_enable),
    .start(start), .busy(busy), .cap_rst(cap_rst), .cap_signal(cap_signal),
    .cap_frequency(cap_frequency), .cap_high_time(cap_high_time),
    .cap_low_time(cap_low_time), .cap_done(cap_done),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_ch(result_ch), .result_freq(result_freq), .result_high(result_high),
    .result_low(result_low), .result_timeout(result_timeout), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int delay; int npulses; int f1; int f2; } plan_t;
  typedef struct { int ch; int freq; int high; int low; int tmo; } beat_t;

  plan_t plan_q[$];
  beat_t exp_q[$];
  beat_t log_q[$];

  int tests = 0, fails = 0;
  int sweeps = 0, sweep_cyc = 0, vrise_cyc = 0, mcount = 0, mentry_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: what the beat for one channel must contain, given what the capture unit does.
  function automatic beat_t model_beat(input int ch, input plan_t p);
    beat_t b;
    bit    hit;
    int    f;
`ifdef CAP_SKIP_FIRST_EN
    hit = (p.npulses >= 2); f = p.f2;
`else
    hit = (p.npulses >= 1); f = p.f1;
`endif
    b.ch = ch;
    b.freq = hit ? f : 0;
    b.high = hit ? f + 1 : 0;
    b.low  = hit ? f + 2 : 0;
    b.tmo  = hit ? 0 : 1;
    return b;
  endfunction

  task automatic add_ch(input int ch, input int delay, input int np, input int f1, input int f2);
    plan_t p;
    p.delay = delay; p.npulses = np; p.f1 = f1; p.f2 = f2;
    plan_q.push_back(p);
    exp_q.push_back(model_beat(ch, p));
  endtask

  task automatic pulse(input int d, input int f);
    repeat (d) @(posedge clk);
    #1;
    cap_frequency = f; cap_high_time = f + 1; cap_low_time = f + 2; cap_done = 1'b1;
    repeat (4) @(posedge clk);
    #1 cap_done = 1'b0;
  endtask

  // Capture-unit stand-in: reacts to each release of cap_rst during a sweep.
  initial begin : responder
    plan_t p;
    logic prv;
    prv = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prv && !cap_rst && busy) begin
        mcount++;
        mentry_cyc = cyc;
        if (plan_q.size() > 0) begin
          p = plan_q.pop_front();
          if (p.npulses >= 1) pulse(p.delay, p.f1);
          if (p.npulses >= 2) pulse(20, p.f2);
        end
      end
      prv = cap_rst;
    end
  end

  initial begin : compare
    logic pv;
    beat_t cur, b;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (result_valid) begin
          b.ch = int'(result_ch); b.freq = int'(result_freq); b.high = int'(result_high);
          b.low = int'(result_low); b.tmo = int'(result_timeout);
          if (!pv) begin
            vrise_cyc = cyc;
            log_q.push_back(b);
            if (exp_q.size() == 0) begin
              check("unexpected_beat", 1, 0);
            end else begin
              check("beat_ch", b.ch, exp_q[0].ch);
              check("beat_freq", b.freq, exp_q[0].freq);
              check("beat_high", b.high, exp_q[0].high);
              check("beat_low", b.low, exp_q[0].low);
              check("beat_timeout", b.tmo, exp_q[0].tmo);
            end
          end else begin
            check("hold_fields", (b.ch == cur.ch && b.freq == cur.freq && b.high == cur.high &&
                                  b.low == cur.low && b.tmo == cur.tmo), 1);
          end
          cur = b;
          if (result_ready && exp_q.size() > 0) void'(exp_q.pop_front());
          check("valid_while_busy", busy, 1);
        end
        if (sweep_done) begin
          sweeps++;
          sweep_cyc = cyc;
          check("done_busy_low", busy, 0);
        end
        if (!busy) check("sig_idle_zero", cap_signal, 0);
        else if (cap_rst && exp_q.size() > 0) check("sig_select", cap_signal, sig_in[exp_q[0].ch]);
        pv = result_valid;
      end
    end
  end

  task automatic do_start(input logic [3:0] m);
    @(posedge clk); #1;
    ch_enable = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_sweep(input int budget);
    int s0;
    s0 = sweeps;
    for (int i = 0; i < budget && sweeps == s0; i++) @(negedge clk);
    check("sweep_within_budget", sweeps != s0, 1);
    check("beats_all_seen", exp_q.size(), 0);
  endtask

  int s_before, p_cyc, m0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_cap_rst", cap_rst, 1);
    check("rst_valid", result_valid, 0);
    check("rst_sweep_done", sweep_done, 0);
    check("rst_freq", result_freq, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_cap_rst", cap_rst, 0);

    // Two enabled channels, each answered after 100 cycles
    log_q.delete(); sig_in = 4'b0100; s_before = sweeps;
    add_ch(0, 100, 1, 10, 0);
    add_ch(2, 100, 1, 50, 0);
    do_start(4'b0101);
    wait_sweep(5000);
    check("t1_sweeps", sweeps - s_before, 1);
    check("t1_nbeats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t1_ch_a", log_q[0].ch, 0);
      check("t1_ch_b", log_q[1].ch, 2);
`ifdef CAP_SKIP_FIRST_EN
      check("t1_freq_a", log_q[0].freq, 0);
      check("t1_freq_b", log_q[1].freq, 0);
`else
      check("t1_freq_a", log_q[0].freq, 10);
      check("t1_freq_b", log_q[1].freq, 50);
      check("t1_tmo_a", log_q[0].tmo, 0);
`endif
    end

    // Silent capture unit: timeout beat exactly TMO cycles after MEASURE entry
    log_q.delete(); sig_in = 4'b0010;
    add_ch(1, 0, 0, 0, 0);
    do_start(4'b0010);
    wait_sweep(3000);
    check("t2_latency", vrise_cyc - mentry_cyc, 1000);
    check("t2_nbeats", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t2_ch", log_q[0].ch, 1);
      check("t2_tmo", log_q[0].tmo, 1);
      check("t2_freq", log_q[0].freq, 0);
    end

    // Back-pressure for 50 cycles, plus two cap_done pulses 7 then 9
    log_q.delete(); sig_in = 4'b0001; result_ready = 1'b0;
    add_ch(0, 30, 2, 7, 9);
    do_start(4'b0001);
    for (int i = 0; i < 3000 && !result_valid; i++) @(negedge clk);
    check("t3_valid_seen", result_valid, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t3_valid_held", result_valid, 1);
      check("t3_index_held", cap_signal, 1);
    end
    @(posedge clk); #1 result_ready = 1'b1;
    wait_sweep(200);
    check("t3_nbeats", log_q.size(), 1);
    if (log_q.size() == 1) begin
`ifdef CAP_SKIP_FIRST_EN
      check("t3_freq", log_q[0].freq, 9);
`else
      check("t3_freq", log_q[0].freq, 7);
`endif
    end

    // Empty mask: sweep_done NUM_CH+2 cycles after start; second start while busy ignored
    log_q.delete(); sig_in = 4'b1111; s_before = sweeps;
    @(posedge clk); #1;
    p_cyc = cyc; ch_enable = 4'b0000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 40 && sweeps == s_before; i++) @(negedge clk);
    check("t4_done_time", sweep_cyc - p_cyc, NUM_CH + 2);
    repeat (30) @(negedge clk);
    check("t4_one_sweep", sweeps - s_before, 1);
    check("t4_no_beats", log_q.size(), 0);

    // Reset during MEASURE of ch1 abandons the sweep
    log_q.delete(); sig_in = 4'b0010; s_before = sweeps;
    add_ch(1, 0, 0, 0, 0);
    m0 = mcount;
    do_start(4'b0010);
    for (int i = 0; i < 100 && mcount == m0; i++) @(negedge clk);
    check("t5_measure_reached", mcount != m0, 1);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_cap_rst", cap_rst, 1);
    check("t5_valid", result_valid, 0);
    exp_q.delete(); plan_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_sweep_done", sweeps - s_before, 0);
    sig_in = 4'b0001;
    add_ch(0, 40, 1, 3, 0);
    add_ch(1, 40, 1, 4, 0);
    do_start(4'b0011);
    wait_sweep(5000);
    check("t5_nbeats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t5_first_ch", log_q[0].ch, 0);
      check("t5_second_ch", log_q[1].ch, 1);
`ifndef CAP_SKIP_FIRST_EN
      check("t5_first_freq", log_q[0].freq, 3);
      check("t5_second_freq", log_q[1].freq, 4);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/capture_channel_scheduler.md
CAPTURE_CHANNEL_SCHEDULER -- requirements
Module: capture_channel_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of input signals sharing one Input_Capture_Module.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000000: per-channel wait limit (2 s at 50 MHz).
REQ-003 Parameter CLR_CYCLES, default 2: cap_rst pulse length, in cycles.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 sig_in  in  NUM_CH  raw signals to measure, already synchronised.
REQ-007 ch_enable  in  NUM_CH  channel mask, sampled on accepted start.
REQ-008 start  in  1  one-cycle sweep request.
REQ-009 busy  out  1  high from accepted start until sweep_done.
REQ-010 cap_rst  out  1  active-high reset to capture unit.
REQ-011 cap_signal  out  1  selected sig_in bit driven to capture unit signal_in.
REQ-012 cap_frequency, cap_high_time, cap_low_time  in  32 each  capture unit results.
REQ-013 cap_done  in  1  capture unit measurement_done.
REQ-014 result_valid  out  1  result beat valid.
REQ-015 result_ready  in  1  consumer accepts beat.
REQ-016 result_ch  out  clog2(NUM_CH)  channel index of beat.
REQ-017 result_freq, result_high, result_low  out  32 each  captured values.
REQ-018 result_timeout  out  1  beat produced by timeout.
REQ-019 sweep_done  out  1  one-cycle pulse at end of sweep.

Function
REQ-020 FSM states SHALL be IDLE, SELECT, CLEAR, MEASURE, OUTPUT, NEXT, DONE.
REQ-021 IDLE: start with busy low SHALL latch ch_enable into mask, set index 0, go SELECT; start while busy SHALL be ignored.
REQ-022 SELECT: if mask[index]=1 go CLEAR, else go NEXT (one cycle per skipped channel).
REQ-023 cap_signal SHALL equal sig_in[index] combinationally in every state except IDLE and DONE, where it SHALL be 0.
REQ-024 CLEAR: cap_rst SHALL be high for exactly CLR_CYCLES cycles, then MEASURE with timeout counter cleared.
REQ-025 MEASURE: a 0->1 edge on cap_done (registered detect, one-cycle latency) SHALL capture cap_frequency/high/low into result registers with result_timeout=0 and go OUTPUT.
REQ-026 MEASURE: timeout counter reaching TIMEOUT_CYCLES-1 without a qualifying edge SHALL load freq/high/low=0, result_timeout=1, go OUTPUT; edge and timeout in same cycle SHALL favour the edge.
REQ-027 OUTPUT: result_valid high, all result fields stable until result_valid & result_ready; then go NEXT in the following cycle.
REQ-028 NEXT: index==NUM_CH-1 go DONE, else index+1 and go SELECT.
REQ-029 DONE: sweep_done high one cycle, busy drops in same cycle, return IDLE.
REQ-030 All-zero mask SHALL produce no result beats and sweep_done NUM_CH+2 cycles after start.
REQ-031 Timeout counter SHALL be 32 bits and SHALL not wrap (saturates by state exit).

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, index 0, counters 0, cap_rst=1, busy=0, result_valid=0, result_* =0, sweep_done=0.
REQ-033 cap_rst SHALL be 0 in all states except CLEAR and reset.
REQ-034 Reset mid-sweep SHALL abandon the sweep without sweep_done; first start after release begins a fresh sweep.

Configuration
REQ-035 Macro CAP_SKIP_FIRST_EN defined: first cap_done edge after CLEAR SHALL be discarded (partial period), second edge captured; timeout counter not restarted by the discarded edge.
REQ-036 CAP_SKIP_FIRST_EN undefined: first cap_done edge after CLEAR SHALL be captured.

Verification
REQ-037 mask=4'b0101, cap_done pulse 100 cycles into each MEASURE with freq 10/50, ready=1 -> beats ch0 freq 10 then ch2 freq 50, timeout=0, one sweep_done.
REQ-038 TIMEOUT_CYCLES=1000, mask=4'b0010, cap_done never -> one beat ch1, timeout=1, freq 0, exactly 1000 cycles after MEASURE entry.
REQ-039 result_ready low 50 cycles during OUTPUT -> result_valid and fields held constant 50 cycles, no index advance.
REQ-040 mask=0 -> no result_valid, sweep_done NUM_CH+2 cycles after start; second start while busy -> no extra sweep.
REQ-041 rst_n low during MEASURE of ch1 -> busy=0, cap_rst=1 immediately, no sweep_done; new start sweeps from ch0.
REQ-042 CAP_SKIP_FIRST_EN defined, two cap_done pulses freq 7 then 9 -> beat freq 9; undefined -> beat freq 7.
